// File: rtl/next_pc_predict.sv
// ---------------------------------------------------------------------------
// next_pc_predict
//   Next-fetch-address selection with a direct-mapped branch target buffer.
//   Each entry holds valid, tag, target and a 2-bit saturating direction
//   counter. The lookup on the fetch PC is purely combinational. Resolved
//   branches from EX/MEM train the table on the rising clock edge.
//   Next-PC priority: EX/MEM redirect, then predicted-taken BTB target,
//   then PC+4.
//
// Ports
//   CLK               in   1   clock, rising edge
//   nRST              in   1   asynchronous reset, active-low
//   current_pc_count  in   32  PC currently in fetch
//   redirect_en       in   1   correction from EX/MEM
//   redirect_pc       in   32  correct fetch address when redirect_en=1
//   update_en         in   1   train the BTB with one resolved branch/jump
//   update_pc         in   32  PC of the resolved branch
//   update_taken      in   1   resolved direction
//   update_target     in   32  resolved target
//   next_pc_count     out 32   next fetch address
//   pred_taken        out  1   next_pc_count came from a taken BTB hit
//   pred_target       out 32   BTB target on hit, else 0
// ---------------------------------------------------------------------------
module next_pc_predict #(
    parameter int IDX_W = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] current_pc_count,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    output logic [31:0] next_pc_count,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int TAG_W   = 30 - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_hit_taken;

    assign w_idx       = current_pc_count[IDX_W+1:2];
    assign w_tag       = current_pc_count[31:IDX_W+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit_taken = w_hit && r_ctr[w_idx][1];

    // A redirect overrides the prediction, so pred_taken is suppressed, but
    // pred_target still reports the raw BTB result for the ID/EX check.
    assign pred_taken  = w_hit_taken && !redirect_en;
    assign pred_target = w_hit ? r_target[w_idx] : 32'h0;

    always_comb begin
        next_pc_count = current_pc_count + 32'd4;
        if (redirect_en) begin
            next_pc_count = redirect_pc;
        end else if (w_hit_taken) begin
            next_pc_count = r_target[w_idx];
        end
    end

    // ---------------- training ----------------
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;

    assign w_uidx = update_pc[IDX_W+1:2];
    assign w_utag = update_pc[31:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    // Byte-offset bits never participate in indexing or tagging.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{current_pc_count[1:0], update_pc[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic w_sel;
            assign w_sel = update_en && (w_uidx == IDX_W'(gi));

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_valid[gi]  <= 1'b0;
                    r_tag[gi]    <= '0;
                    r_target[gi] <= 32'h0;
                    r_ctr[gi]    <= 2'b01;
                end else if (w_sel) begin
                    if (w_uhit) begin
                        if (update_taken) begin
                            if (r_ctr[gi] != 2'b11) begin
                                r_ctr[gi] <= r_ctr[gi] + 2'b01;
                            end
                            r_target[gi] <= update_target;
                        end else if (r_ctr[gi] != 2'b00) begin
                            r_ctr[gi] <= r_ctr[gi] - 2'b01;
                        end
                    end else if (update_taken) begin
                        // Miss on a taken branch: allocate or evict the alias.
                        r_valid[gi]  <= 1'b1;
                        r_tag[gi]    <= w_utag;
                        r_target[gi] <= update_target;
                        r_ctr[gi]    <= 2'b10;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_next_pc_predict.sv
module tb_next_pc_predict;

    logic        CLK;
    logic        nRST;
    logic [31:0] current_pc_count;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [31:0] next_pc_count;
    logic        pred_taken;
    logic [31:0] pred_target;

    next_pc_predict #(.IDX_W(4)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .current_pc_count (current_pc_count),
        .redirect_en      (redirect_en),
        .redirect_pc      (redirect_pc),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .next_pc_count    (next_pc_count),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] nxt;
        logic        pt;
        logic [31:0] ptgt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_strobe;
    int    n_compared;
    int    n_mismatched;

    // Monitor: samples on the falling edge whenever the stimulus flagged a
    // transaction for this cycle, pops the expected result and compares.
    always @(negedge CLK) begin
        if (chk_strobe) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL no_expectation: got next=%08h pt=%0b tgt=%08h, required a queued expectation",
                         next_pc_count, pred_taken, pred_target);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (next_pc_count !== e.nxt || pred_taken !== e.pt || pred_target !== e.ptgt) begin
                    n_mismatched++;
                    $display("FAIL %s: got next=%08h pt=%0b tgt=%08h, required next=%08h pt=%0b tgt=%08h",
                             nm, next_pc_count, pred_taken, pred_target, e.nxt, e.pt, e.ptgt);
                end else begin
                    $display("ok   %s: next=%08h pt=%0b tgt=%08h", nm, next_pc_count, pred_taken, pred_target);
                end
            end
        end
    end

    // One cycle of stimulus: drive just after the rising edge, queue the
    // expected combinational response for this cycle's inputs.
    task automatic step(input logic [31:0] pc,
                        input logic rd, input logic [31:0] rpc,
                        input logic ue, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt,
                        input logic rstn,
                        input logic [31:0] e_nxt, input logic e_pt,
                        input logic [31:0] e_tgt, input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST             = rstn;
        current_pc_count = pc;
        redirect_en      = rd;
        redirect_pc      = rpc;
        update_en        = ue;
        update_pc        = upc;
        update_taken     = ut;
        update_target    = utgt;
        e.nxt  = e_nxt;
        e.pt   = e_pt;
        e.ptgt = e_tgt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_strobe = 1'b1;
    endtask

    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        chk_strobe       = 1'b0;
        nRST             = 1'b0;
        current_pc_count = 32'h40;
        redirect_en      = 1'b0;
        redirect_pc      = 32'h0;
        update_en        = 1'b0;
        update_pc        = 32'h0;
        update_taken     = 1'b0;
        update_target    = 32'h0;
        repeat (3) @(posedge CLK);

        //     pc            rd rpc        ue upc        ut utgt       rst exp_next      pt exp_tgt
        step(32'h40,       0, 0,         0, 0,         0, 0,         1, 32'h44,       0, 32'h0,   "reset_pc_plus4");
        step(32'h40,       0, 0,         1, 32'h40,    1, 32'h100,   1, 32'h44,       0, 32'h0,   "alloc_same_cycle_old");
        step(32'h40,       0, 0,         0, 0,         0, 0,         1, 32'h100,      1, 32'h100, "alloc_hit_ctr10");
        step(32'h40,       0, 0,         1, 32'h40,    0, 0,         1, 32'h100,      1, 32'h100, "nt1_pre");
        step(32'h40,       0, 0,         1, 32'h40,    0, 0,         1, 32'h44,       0, 32'h100, "ctr01_not_taken");
        step(32'h40,       0, 0,         1, 32'h40,    0, 0,         1, 32'h44,       0, 32'h100, "ctr00_floor");
        step(32'h40,       0, 0,         1, 32'h40,    1, 32'h100,   1, 32'h44,       0, 32'h100, "ctr00_then_taken");
        step(32'h40,       0, 0,         1, 32'h40,    1, 32'h100,   1, 32'h44,       0, 32'h100, "ctr01_still_nt");
        step(32'h40,       0, 0,         1, 32'h40,    1, 32'h100,   1, 32'h100,      1, 32'h100, "ctr10_taken_again");
        step(32'h40,       0, 0,         1, 32'h40,    1, 32'h100,   1, 32'h100,      1, 32'h100, "ctr11_saturate");
        step(32'h40,       0, 0,         1, 32'h40,    0, 0,         1, 32'h100,      1, 32'h100, "ctr11_held");
        step(32'h40,       0, 0,         0, 0,         0, 0,         1, 32'h100,      1, 32'h100, "ctr10_after_dec");
        // aliasing on index 0
        step(32'h40,       0, 0,         1, 32'h80,    1, 32'h200,   1, 32'h100,      1, 32'h100, "alias_update_pre");
        step(32'h40,       0, 0,         0, 0,         0, 0,         1, 32'h44,       0, 32'h0,   "alias_evicted_miss");
        step(32'h80,       0, 0,         1, 32'h40,    0, 0,         1, 32'h200,      1, 32'h200, "alias_hit_nt_miss_upd");
        step(32'h40,       0, 0,         0, 0,         0, 0,         1, 32'h44,       0, 32'h0,   "nt_miss_no_alloc");
        step(32'h80,       0, 0,         0, 0,         0, 0,         1, 32'h200,      1, 32'h200, "alias_entry_intact");
        // redirect priority and wraparound
        step(32'h80,       1, 32'h300,   0, 0,         0, 0,         1, 32'h300,      0, 32'h200, "redirect_over_hit");
        step(32'hFFFFFFFC, 0, 0,         0, 0,         0, 0,         1, 32'h0,        0, 32'h0,   "pc_wrap");
        step(32'hFFFFFFFC, 1, 32'h500,   1, 32'h1F,    1, 32'h77C,   1, 32'h500,      0, 32'h0,   "redirect_and_update");
        step(32'h1C,       0, 0,         0, 0,         0, 0,         1, 32'h77C,      1, 32'h77C, "update_lsb_ignored");
        step(32'h1E,       0, 0,         0, 0,         0, 0,         1, 32'h77C,      1, 32'h77C, "lookup_lsb_ignored");
        // same-cycle lookup and update on index 0
        step(32'h80,       0, 0,         1, 32'h80,    0, 0,         1, 32'h200,      1, 32'h200, "same_cycle_old");
        step(32'h80,       0, 0,         0, 0,         0, 0,         1, 32'h84,       0, 32'h200, "same_cycle_new");
        // asynchronous reset mid-stream
        step(32'h80,       0, 0,         0, 0,         0, 0,         0, 32'h84,       0, 32'h0,   "in_reset_miss");
        step(32'h80,       1, 32'h300,   0, 0,         0, 0,         0, 32'h300,      0, 32'h0,   "in_reset_redirect");
        step(32'h1C,       0, 0,         0, 0,         0, 0,         1, 32'h20,       0, 32'h0,   "post_reset_idx7_miss");
        step(32'h80,       0, 0,         0, 0,         0, 0,         1, 32'h84,       0, 32'h0,   "post_reset_idx0_miss");

        @(posedge CLK);
        #1;
        chk_strobe = 1'b0;
        repeat (2) @(posedge CLK);
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: got %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
